// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/execute control unit for register-to-register instructions,
// with pause, halt, sticky illegal-opcode flag and a retired-instruction counter.
module control_sequencer #(
  parameter int ICNT_W = 16
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic [31:0]       IR,
  input  logic              Stop,
  output logic              PCout,
  output logic              Zhighout,
  output logic              Zlowout,
  output logic              MDRout,
  output logic              Rout,
  output logic              MARin,
  output logic              PCin,
  output logic              MDRin,
  output logic              IRin,
  output logic              Yin,
  output logic              Zin,
  output logic              Rin,
  output logic              Gra,
  output logic              Grb,
  output logic              Grc,
  output logic              IncPC,
  output logic              Read,
  output logic [4:0]        alu_op,
  output logic              Run,
  output logic              Illegal,
  output logic [ICNT_W-1:0] icount
);
  typedef enum logic [3:0] {S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_PAUSE, S_HALT} state_t;
  state_t state_q, state_d;
  logic illegal_q, illegal_d;
  logic [ICNT_W-1:0] icount_q, icount_d;
  logic [4:0] opcode;
  logic is_alu, is_nop, is_halt, is_ill, end_instr, retire;
  assign opcode  = IR[31:27];
  assign is_alu  = opcode[4:3] == 2'b00;
  assign is_nop  = opcode == 5'b11110;
  assign is_halt = opcode == 5'b11111;
  assign is_ill  = !is_alu && !is_nop && !is_halt;
  // T3 finishes nop/illegal; ALU ops finish in T5; halt retires on entry to Halt
  assign end_instr = (state_q == S_T5) || (state_q == S_T3 && (is_nop || is_ill));
  assign retire    = end_instr || (state_q == S_T3 && is_halt);
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state_q   <= S_RST;
      illegal_q <= 1'b0;
      icount_q  <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      icount_q  <= icount_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q | (state_q == S_T3 && is_ill);
    icount_d  = icount_q + ICNT_W'(retire);
    case (state_q)
      S_RST:   state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2:    state_d = S_T3;
      S_T3:    state_d = is_alu ? S_T4 : is_halt ? S_HALT : Stop ? S_PAUSE : S_T0;
      S_T4:    state_d = S_T5;
      S_T5:    state_d = Stop ? S_PAUSE : S_T0;
      S_PAUSE: state_d = Stop ? S_PAUSE : S_T0;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end
  assign PCout    = state_q == S_T0;
  assign MARin    = state_q == S_T0;
  assign IncPC    = state_q == S_T0;
  assign Zhighout = 1'b0;
  assign Zlowout  = state_q == S_T1 || state_q == S_T5;
  assign PCin     = state_q == S_T1;
  assign Read     = state_q == S_T1;
  assign MDRin    = state_q == S_T1;
  assign MDRout   = state_q == S_T2;
  assign IRin     = state_q == S_T2;
  assign Grb      = state_q == S_T3 && is_alu;
  assign Yin      = state_q == S_T3 && is_alu;
  assign Rout     = (state_q == S_T3 && is_alu) || state_q == S_T4;
  assign Grc      = state_q == S_T4;
  assign Zin      = state_q == S_T0 || state_q == S_T4;
  assign alu_op   = state_q == S_T4 ? opcode : 5'b00000;
  assign Gra      = state_q == S_T5;
  assign Rin      = state_q == S_T5;
  assign Run      = state_q inside {S_T0, S_T1, S_T2, S_T3, S_T4, S_T5};
  assign Illegal  = illegal_q;
  assign icount   = icount_q;
endmodule
